// File: rtl/np_imem_loader.sv
// Instruction-memory stage for the np core: owns the 4096x32 program store, fills it
// from a valid/ready word stream, sequences the core's reset and detects halt.
module np_imem_loader #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12,
    parameter int MEMSIZE  = 1 << ADDRSIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ld_valid,
    input  logic [WIDTH-1:0]    ld_data,
    input  logic                ld_last,
    output logic                ld_ready,
    input  logic [ADDRSIZE-1:0] in_address,
    input  logic                in_wr,
    input  logic [WIDTH-1:0]    in_dataOut,
    output logic [WIDTH-1:0]    in_dataIn,
    input  logic                halt,
    output logic                cpu_reset,
    output logic                running,
    output logic                done,
    output logic                trunc,
    output logic [ADDRSIZE:0]   load_count,
    output logic [31:0]         cycle_count
);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_START   = 2'd1,
        S_RUN     = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

    localparam logic [ADDRSIZE-1:0] PTR_LAST = ADDRSIZE'(MEMSIZE - 1);
    localparam logic [ADDRSIZE-1:0] PTR_ONE  = ADDRSIZE'(1);
    localparam logic [ADDRSIZE:0]   CNT_ONE  = (ADDRSIZE+1)'(1);

    state_t                state_reg, state_next;
    logic [ADDRSIZE-1:0]   ptr_reg, ptr_next;
    logic [ADDRSIZE:0]     load_count_reg, load_count_next;
    logic [31:0]           cycle_count_reg, cycle_count_next;
    logic                  trunc_reg, trunc_next;
    logic                  start_cnt_reg, start_cnt_next;

    logic [WIDTH-1:0]      mem [MEMSIZE];
    logic                  mem_we;
    logic [ADDRSIZE-1:0]   mem_waddr;
    logic [WIDTH-1:0]      mem_wdata;
    logic                  accept;

    assign ld_ready    = (state_reg == S_LOAD) || (state_reg == S_HALTED);
    assign accept      = ld_valid && ld_ready;
    assign cpu_reset   = (state_reg != S_RUN);
    assign running     = (state_reg == S_RUN);
    assign done        = (state_reg == S_HALTED);
    assign trunc       = trunc_reg;
    assign load_count  = load_count_reg;
    assign cycle_count = cycle_count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= S_LOAD;
            ptr_reg         <= '0;
            load_count_reg  <= '0;
            cycle_count_reg <= '0;
            trunc_reg       <= 1'b0;
            start_cnt_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ptr_reg         <= ptr_next;
            load_count_reg  <= load_count_next;
            cycle_count_reg <= cycle_count_next;
            trunc_reg       <= trunc_next;
            start_cnt_reg   <= start_cnt_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        ptr_next         = ptr_reg;
        load_count_next  = load_count_reg;
        cycle_count_next = cycle_count_reg;
        trunc_next       = trunc_reg;
        start_cnt_next   = start_cnt_reg;
        mem_we           = 1'b0;
        mem_waddr        = ptr_reg;
        mem_wdata        = ld_data;

        case (state_reg)
            S_LOAD: begin
                if (accept) begin
                    mem_we          = 1'b1;
                    load_count_next = load_count_reg + CNT_ONE;
                    // Pointer parks on the last word so a full memory never wraps onto word 0.
                    if (ptr_reg != PTR_LAST) begin
                        ptr_next = ptr_reg + PTR_ONE;
                    end
                    if (ld_last) begin
                        state_next = S_START;
                    end else if (ptr_reg == PTR_LAST) begin
                        state_next = S_START;
                        trunc_next = 1'b1;
                    end
                end
            end
            S_START: begin
                // Two reset cycles so the core's synchronous reset is seen on at least one edge.
                if (start_cnt_reg) begin
                    start_cnt_next = 1'b0;
                    state_next     = S_RUN;
                end else begin
                    start_cnt_next = 1'b1;
                end
            end
            S_RUN: begin
                if (cycle_count_reg != '1) begin
                    cycle_count_next = cycle_count_reg + 32'd1;
                end
                if (in_wr) begin
                    mem_we    = 1'b1;
                    mem_waddr = in_address;
                    mem_wdata = in_dataOut;
                end
                if (halt) begin
                    state_next = S_HALTED;
                end
            end
            S_HALTED: begin
                // First word of the next program is taken here, written at address 0.
                if (accept) begin
                    mem_we           = 1'b1;
                    mem_waddr        = '0;
                    ptr_next         = PTR_ONE;
                    load_count_next  = CNT_ONE;
                    trunc_next       = 1'b0;
                    cycle_count_next = '0;
                    state_next       = ld_last ? S_START : S_LOAD;
                end
            end
            default: begin
                state_next = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we && reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign in_dataIn = mem[in_address];

endmodule
